sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised single-clock FIFO, the successor to the fixed 8-entry buffer. It adds generic width and depth, simultaneous push/pop, an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It sits between a producer and a consumer on the same clock and uses show-ahead reads: the head word is always visible on `data_rd`.

## Interface
Parameters:
- `DW`, 8, data width in bits (≥1)
- `DEPTH`, 8, number of entries; power of two, ≥2
- `AF_THRESH`, DEPTH-1, `almost_full` asserts when count ≥ AF_THRESH (1..DEPTH)
- `AE_THRESH`, 1, `almost_empty` asserts when count ≤ AE_THRESH (0..DEPTH-1)

Ports (AW = $clog2(DEPTH)):
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  reset, synchronous, active-high
- `push`  in  1  write request
- `data_wr`  in  DW  write data, sampled when push accepted
- `pop`  in  1  read request; consumes current `data_rd`
- `clr_err`  in  1  clears sticky error flags
- `data_rd`  out  DW  head-of-FIFO word (show-ahead); undefined while empty
- `empty`  out  1  no valid entries
- `full`  out  1  DEPTH valid entries
- `almost_empty`  out  1  count ≤ AE_THRESH
- `almost_full`  out  1  count ≥ AF_THRESH
- `count`  out  AW+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: push attempted while full
- `underflow`  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×DW array; `wrptr`, `rdptr` are AW+1 bits (extra wrap bit). Index = low AW bits; natural modulo-2^(AW+1) wrap.
- Accept rules (using registered flags): `wr_en = push & ~full`; `rd_en = pop & ~empty`.
- wr_en: mem[wrptr[AW-1:0]] ← data_wr; wrptr += 1. rd_en: rdptr += 1.
- `count_next = count + wr_en − rd_en`; both accepted → count unchanged, both pointers advance.
- Push+pop while full: pop accepted, push rejected, `overflow` set. Push+pop while empty: push accepted, pop rejected, `underflow` set. No write-through or bypass.
- Flags registered, derived from `count_next`: empty = (count_next==0), full = (count_next==DEPTH), almost_* per thresholds.
- Errors: set on rejected request; held until `clr_err` or `rst`. If `clr_err` and a new error occur in the same cycle, the flag stays set.
- Memory contents are not reset; only pointers, count and flags.
- No FSM; state is pointers + count + flags.

## Timing
- Reset values: wrptr=rdptr=0, count=0, empty=1, full=0, almost_empty=1 (AE_THRESH≥0), almost_full=0, overflow=underflow=0. Reset wins over all concurrent requests; mid-operation reset discards contents in one cycle.
- Write-to-read latency: a word pushed into an empty FIFO at edge N appears on `data_rd` with `empty`=0 after edge N (usable for pop in cycle N+1).
- `data_rd` is combinational from mem[rdptr]; updates the cycle after a pop.
- All status outputs are valid one cycle after the causing edge; no combinational path from push/pop to any output.

## Structure
- Package `fifo_pkg`: `clog2`-based width helper function, parameter legality checks (power-of-two DEPTH, threshold ranges) as elaboration-time functions.
- Sub-module `fifo_mem` (DEPTH×DW, 1 write port, 1 async read port) so the array can be swapped for a macro.
- Formal: assertions for count==wrptr−rdptr, ¬(full∧empty), pointer advance on accept, error stickiness, under `FORMAL`.

## Test plan
- Reset then push 0x11..0x18 (DEPTH=8) → count=8, full=1, almost_full=1 from count 7; pops return 0x11..0x18 in order, empty=1 at end.
- Full, push+pop same cycle with data 0xAA → 0x11 popped, 0xAA dropped, count=7, overflow=1; overflow holds until clr_err pulse then 0.
- Empty, push 0x5C + pop same cycle → count=1, data_rd=0x5C, underflow=1.
- Half-full (count=4), 20 cycles of simultaneous push/pop with incrementing data → count stays 4, output sequence intact across pointer wrap.
- AF_THRESH=6, AE_THRESH=2: walk count 0→8→0 → almost_empty high for 0..2, almost_full high for 6..8, one cycle after each edge.
- Reset asserted with count=5 and push active → next cycle count=0, empty=1, errors 0, push ignored.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the sync_fifo slice: pointer/address width and
// elaboration-time legality checks on the FIFO parameters.
package fifo_pkg;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit af_legal(input int af, input int depth);
        return (af >= 1) && (af <= depth);
    endfunction

    function automatic bit ae_legal(input int ae, input int depth);
        return (ae >= 0) && (ae < depth);
    endfunction

    function automatic bit params_legal(input int dw, input int depth,
                                        input int af, input int ae);
        return (dw >= 1) && is_pow2(depth) && af_legal(af, depth) && ae_legal(ae, depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// Kept separate so it can be replaced by a hard macro.
module fifo_mem #(
    parameter int DW = 8,
    parameter int DEPTH = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock show-ahead FIFO with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int DEPTH = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            data_wr,
    input  logic                     pop,
    input  logic                     clr_err,
    output logic [DW-1:0]            data_rd,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [addr_w(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = addr_w(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    if (!params_legal(DW, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo: illegal DW/DEPTH/threshold combination");
    end

    logic [AW:0] wrptr;
    logic [AW:0] rdptr;
    logic [AW:0] count_next;
    logic        wr_en;
    logic        rd_en;

    // Accept decisions use the registered flags, so push/pop never reach an output combinationally.
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    always_comb begin
        count_next = count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr        <= '0;
            rdptr        <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_en) begin
                wrptr <= wrptr + ONE;
            end
            if (rd_en) begin
                rdptr <= rdptr + ONE;
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_C);
            almost_empty <= (count_next <= AE_C);
            almost_full  <= (count_next >= AF_C);
            // A new error in the clearing cycle wins over the clear.
            overflow     <= (overflow & ~clr_err) | (push & full);
            underflow    <= (underflow & ~clr_err) | (pop & empty);
        end
    end

    fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wrptr[AW-1:0]),
        .wdata (data_wr),
        .raddr (rdptr[AW-1:0]),
        .rdata (data_rd)
    );

`ifdef FORMAL
    a_count_ptr: assert property (@(posedge clk) disable iff (rst) count == wrptr - rdptr);
    a_not_full_empty: assert property (@(posedge clk) disable iff (rst) !(full && empty));
    a_wr_adv: assert property (@(posedge clk) disable iff (rst) wr_en |=> wrptr == $past(wrptr) + ONE);
    a_rd_adv: assert property (@(posedge clk) disable iff (rst) rd_en |=> rdptr == $past(rdptr) + ONE);
    a_ovf_sticky: assert property (@(posedge clk) disable iff (rst) overflow && !clr_err |=> overflow);
    a_unf_sticky: assert property (@(posedge clk) disable iff (rst) underflow && !clr_err |=> underflow);
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_wr = '0;

    logic [7:0] data_rd, data_rd2;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic       empty2, full2, almost_empty2, almost_full2, overflow2, underflow2;
    logic [3:0] count, count2;

    int total = 0;
    int bad = 0;

    logic [7:0] q[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    bit chk_en = 1'b0;
    bit acc_w, acc_r, new_o, new_u;

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk(clk), .rst(rst), .push(push), .data_wr(data_wr), .pop(pop), .clr_err(clr_err),
        .data_rd(data_rd), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo #(.AF_THRESH(6), .AE_THRESH(2)) dut2 (
        .clk(clk), .rst(rst), .push(push), .data_wr(data_wr), .pop(pop), .clr_err(clr_err),
        .data_rd(data_rd2), .empty(empty2), .full(full2), .almost_empty(almost_empty2),
        .almost_full(almost_full2), .count(count2), .overflow(overflow2), .underflow(underflow2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted words plus sticky error bits.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            new_o = push && (q.size() == DEPTH);
            new_u = pop && (q.size() == 0);
            acc_w = push && (q.size() < DEPTH);
            acc_r = pop && (q.size() > 0);
            if (acc_r) void'(q.pop_front());
            if (acc_w) q.push_back(data_wr);
            m_ovf = new_o || (m_ovf && !clr_err);
            m_unf = new_u || (m_unf && !clr_err);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("count", 32'(count), 32'(q.size()));
            check("empty", 32'(empty), 32'(q.size() == 0));
            check("full", 32'(full), 32'(q.size() == DEPTH));
            check("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - 1));
            check("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("underflow", 32'(underflow), 32'(m_unf));
            check("count2", 32'(count2), 32'(q.size()));
            check("almost_full2", 32'(almost_full2), 32'(q.size() >= 6));
            check("almost_empty2", 32'(almost_empty2), 32'(q.size() <= 2));
            if (q.size() > 0) begin
                check("data_rd", 32'(data_rd), 32'(q[0]));
                check("data_rd2", 32'(data_rd2), 32'(q[0]));
            end
        end
    end

    task automatic step(input bit p, input logic [7:0] d, input bit po, input bit c);
        push = p;
        data_wr = d;
        pop = po;
        clr_err = c;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_ae", 32'(almost_empty), 1);

        // Fill 0x11..0x18
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            check("fill_af", 32'(almost_full), 32'((i + 1) >= 7));
        end
        check("fill_count", 32'(count), 8);
        check("fill_full", 32'(full), 1);

        // Push+pop while full: pop wins, push dropped
        check("ovf_head", 32'(data_rd), 32'h11);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check("ovf_count", 32'(count), 7);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_next", 32'(data_rd), 32'h12);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf_hold", 32'(overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 0);

        for (int i = 0; i < 7; i++) begin
            check("drain", 32'(data_rd), 32'(8'h12 + i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(empty), 1);

        // Push+pop while empty
        step(1'b1, 8'h5C, 1'b1, 1'b0);
        check("unf_count", 32'(count), 1);
        check("unf_data", 32'(data_rd), 32'h5C);
        check("unf_flag", 32'(underflow), 1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("unf_clr", 32'(underflow), 0);
        check("unf_empty", 32'(empty), 1);

        // Steady half-full streaming across pointer wrap
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("wrap_rd", 32'(data_rd), 32'(i));
            step(1'b1, 8'(4 + i), 1'b1, 1'b0);
        end
        check("wrap_count", 32'(count), 4);
        check("wrap_tail", 32'(data_rd), 20);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Threshold walk on the AF=6/AE=2 instance
        for (int c = 1; c <= 8; c++) begin
            step(1'b1, 8'(8'h30 + c), 1'b0, 1'b0);
            check("walk_up_af2", 32'(almost_full2), 32'(c >= 6));
            check("walk_up_ae2", 32'(almost_empty2), 32'(c <= 2));
        end
        for (int c = 7; c >= 0; c--) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("walk_dn_af2", 32'(almost_full2), 32'(c >= 6));
            check("walk_dn_ae2", 32'(almost_empty2), 32'(c <= 2));
        end

        // Reset mid-operation with push active
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 5);
        check("pre_rst_unf", 32'(underflow), 1);
        rst = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_mid_count", 32'(count), 0);
        check("rst_mid_empty", 32'(empty), 1);
        check("rst_mid_ovf", 32'(overflow), 0);
        check("rst_mid_unf", 32'(underflow), 0);

        // Randomized traffic with phases biased toward filling, draining and balance
        for (int k = 0; k < 4000; k++) begin
            automatic int pp;
            automatic int ph = (k / 250) % 3;
            pp = (ph == 0) ? 80 : ((ph == 1) ? 25 : 55);
            rst = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 99) < pp, 8'($urandom),
                 $urandom_range(0, 99) < (100 - pp), $urandom_range(0, 39) == 0);
        end
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
